ysyx_24110006_trap: RTL and testbench
=====================================

YSYX_24110006_TRAP -- requirements
Module: ysyx_24110006_TRAP

Interface
REQ-001 SHALL have parameter TGT_MASK, default 32'hFFFF_FFFC; AND-mask applied to every redirect target.
REQ-002 SHALL have port i_clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port i_exc_valid, input, 1, trap request present.
REQ-005 SHALL have port i_exc_ecall, input, 1, request is ECALL.
REQ-006 SHALL have port i_exc_mret, input, 1, request is MRET.
REQ-007 SHALL have port i_pc, input, 32, PC of the trapping instruction.
REQ-008 SHALL have port i_mcause, input, 32, cause code for ECALL.
REQ-009 SHALL have port o_exc_ready, output, 1, request accepted this cycle when high with i_exc_valid.
REQ-010 SHALL have port o_csr_wen, output, 1, CSR write strobe.
REQ-011 SHALL have port o_csr_addr, output, 12, CSR address for read and write.
REQ-012 SHALL have port o_csr_wdata, output, 32, CSR write data.
REQ-013 SHALL have port i_csr_rdata, input, 32, combinational read of CSR at o_csr_addr.
REQ-014 SHALL have port o_redirect_valid, output, 1, new PC available.
REQ-015 SHALL have port o_redirect_pc, output, 32, redirect target.
REQ-016 SHALL have port i_redirect_ready, input, 1, fetch consumes redirect.
REQ-017 SHALL have port o_busy, output, 1, high whenever state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, W_EPC, W_CAUSE, W_STAT, R_TGT, REDIR.
REQ-019 SHALL drive o_exc_ready = 1 only in IDLE.
REQ-020 SHALL accept on i_exc_valid & o_exc_ready; ignore requests with both ecall and mret low (stay IDLE).
REQ-021 SHALL give ECALL priority when i_exc_ecall and i_exc_mret are both high.
REQ-022 SHALL register i_pc, i_mcause and kind (ecall/mret) at acceptance; later input changes have no effect.
REQ-023 ECALL sequence SHALL be IDLE->W_EPC->W_CAUSE->W_STAT->R_TGT->REDIR, one cycle per state except REDIR.
REQ-024 MRET sequence SHALL be IDLE->W_STAT->R_TGT->REDIR.
REQ-025 W_EPC SHALL drive wen=1, addr=12'h341, wdata=captured pc.
REQ-026 W_CAUSE SHALL drive wen=1, addr=12'h342, wdata=captured mcause.
REQ-027 W_STAT SHALL drive wen=1, addr=12'h300, wdata = i_csr_rdata modified in the same cycle.
REQ-028 ECALL mstatus update: MPIE(bit7)=old MIE(bit3), MIE=0, MPP(bits12:11)=2'b11, other bits unchanged.
REQ-029 MRET mstatus update: MIE=old MPIE, MPIE=1, MPP=2'b11, other bits unchanged.
REQ-030 R_TGT SHALL drive wen=0, addr=12'h305 (ECALL) or 12'h341 (MRET), and capture i_csr_rdata & TGT_MASK into the target register.
REQ-031 REDIR SHALL hold o_redirect_valid=1 and o_redirect_pc stable until i_redirect_ready; the handshake cycle returns to IDLE.
REQ-032 A new request SHALL NOT be accepted in the REDIR->IDLE handshake cycle; earliest acceptance is the following cycle.
REQ-033 Outside W_* states SHALL drive o_csr_wen=0; in IDLE and REDIR o_csr_addr=0, o_csr_wdata=0.
REQ-034 ECALL latency acceptance->o_redirect_valid SHALL be 5 cycles; MRET 3 cycles.

Reset
REQ-035 i_reset SHALL force IDLE on the next edge from any state, aborting a sequence mid-way; no further CSR writes from the aborted trap.
REQ-036 After reset: o_exc_ready=1, o_busy=0, o_csr_wen=0, o_csr_addr=0, o_csr_wdata=0, o_redirect_valid=0, o_redirect_pc=0, captured registers=0.
REQ-037 A request presented while i_reset is high SHALL NOT be accepted.

Verification
REQ-038 ECALL pc=32'h8000_0010, mcause=11, mstatus=32'h0000_0008, mtvec=32'h8000_0103 -> writes 341<=8000_0010, 342<=0000_000B, 300<=0000_1880; redirect 8000_0100 at cycle 5.
REQ-039 MRET, mstatus=32'h0000_1880, mepc=32'h8000_0014 -> write 300<=0000_1888; redirect 8000_0014 at cycle 3.
REQ-040 ECALL and MRET both high, pc=32'h8000_0020 -> ECALL sequence executed, 341<=8000_0020.
REQ-041 i_redirect_ready held low 4 cycles in REDIR -> valid and pc stable 4 cycles; o_exc_ready rises 1 cycle after handshake.
REQ-042 i_reset asserted in W_CAUSE of an ECALL -> next cycle IDLE, no 342/300 write, o_redirect_valid never asserted.
REQ-043 i_exc_valid=1 with ecall=0, mret=0 -> no state change, no CSR writes.

Source files
------------

// File: rtl/ysyx_24110006_trap.sv
// Trap sequencer: on ECALL/MRET, steps through the machine-mode CSR updates
// (mepc, mcause, mstatus), reads the target CSR and hands a redirect PC to fetch.
module ysyx_24110006_trap #(
  parameter logic [31:0] TGT_MASK = 32'hFFFF_FFFC
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_exc_valid,
  input  logic        i_exc_ecall,
  input  logic        i_exc_mret,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_mcause,
  output logic        o_exc_ready,
  output logic        o_csr_wen,
  output logic [11:0] o_csr_addr,
  output logic [31:0] o_csr_wdata,
  input  logic [31:0] i_csr_rdata,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  input  logic        i_redirect_ready,
  output logic        o_busy
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CSR_AW = 12;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_EPC   = 3'd1,
    W_CAUSE = 3'd2,
    W_STAT  = 3'd3,
    R_TGT   = 3'd4,
    REDIR   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   tgt_q, tgt_d;
  logic              ecall_q, ecall_d;
  logic              accept_c;
  logic [XLEN-1:0]   mstatus_new_c;

  // Requests with neither kind set are not traps and are left pending in IDLE.
  assign accept_c = (state_q == IDLE) && i_exc_valid && (i_exc_ecall || i_exc_mret);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      tgt_q   <= '0;
      ecall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      tgt_q   <= tgt_d;
      ecall_q <= ecall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    tgt_d   = tgt_q;
    ecall_d = ecall_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          pc_d    = i_pc;
          cause_d = i_mcause;
          ecall_d = i_exc_ecall;
          state_d = i_exc_ecall ? W_EPC : W_STAT;
        end
      end
      W_EPC:   state_d = W_CAUSE;
      W_CAUSE: state_d = W_STAT;
      W_STAT:  state_d = R_TGT;
      R_TGT: begin
        tgt_d   = i_csr_rdata & TGT_MASK;
        state_d = REDIR;
      end
      REDIR: begin
        if (i_redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // mstatus read-modify-write: ECALL stacks MIE into MPIE, MRET restores it.
  always_comb begin
    mstatus_new_c = i_csr_rdata;
    if (ecall_q) begin
      mstatus_new_c[7] = i_csr_rdata[3];
      mstatus_new_c[3] = 1'b0;
    end else begin
      mstatus_new_c[3] = i_csr_rdata[7];
      mstatus_new_c[7] = 1'b1;
    end
    mstatus_new_c[12:11] = 2'b11;
  end

  // Write strobe is suppressed while reset is held so an aborted trap writes nothing more.
  always_comb begin
    o_exc_ready      = 1'b0;
    o_csr_wen        = 1'b0;
    o_csr_addr       = '0;
    o_csr_wdata      = '0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;
    o_busy           = (state_q != IDLE);
    case (state_q)
      IDLE: o_exc_ready = 1'b1;
      W_EPC: begin
        o_csr_wen   = ~i_reset;
        o_csr_addr  = CSR_MEPC;
        o_csr_wdata = pc_q;
      end
      W_CAUSE: begin
        o_csr_wen   = ~i_reset;
        o_csr_addr  = CSR_MCAUSE;
        o_csr_wdata = cause_q;
      end
      W_STAT: begin
        o_csr_wen   = ~i_reset;
        o_csr_addr  = CSR_MSTATUS;
        o_csr_wdata = mstatus_new_c;
      end
      R_TGT: o_csr_addr = ecall_q ? CSR_MTVEC : CSR_MEPC;
      REDIR: begin
        o_redirect_valid = 1'b1;
        o_redirect_pc    = tgt_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24110006_trap.sv
// Bench for the trap sequencer: a small CSR file answers the DUT, and a
// transaction-level model predicts CSR writes, redirect target and latency.
module tb_ysyx_24110006_trap;

  localparam logic [31:0] TB_MASK = 32'hFFFF_FFFC;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_exc_valid;
  logic        i_exc_ecall;
  logic        i_exc_mret;
  logic [31:0] i_pc;
  logic [31:0] i_mcause;
  logic        o_exc_ready;
  logic        o_csr_wen;
  logic [11:0] o_csr_addr;
  logic [31:0] o_csr_wdata;
  logic [31:0] i_csr_rdata;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;
  logic        i_redirect_ready;
  logic        o_busy;

  logic [31:0] csr_mem [4096];
  logic [43:0] obs_q [$];
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
  int n_chk  = 0;
  int n_pass = 0;

  ysyx_24110006_trap #(.TGT_MASK(TB_MASK)) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_exc_valid      (i_exc_valid),
    .i_exc_ecall      (i_exc_ecall),
    .i_exc_mret       (i_exc_mret),
    .i_pc             (i_pc),
    .i_mcause         (i_mcause),
    .o_exc_ready      (o_exc_ready),
    .o_csr_wen        (o_csr_wen),
    .o_csr_addr       (o_csr_addr),
    .o_csr_wdata      (o_csr_wdata),
    .i_csr_rdata      (i_csr_rdata),
    .o_redirect_valid (o_redirect_valid),
    .o_redirect_pc    (o_redirect_pc),
    .i_redirect_ready (i_redirect_ready),
    .o_busy           (o_busy)
  );

  always #5 i_clock = ~i_clock;

  assign i_csr_rdata = csr_mem[o_csr_addr];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [31:0] ms_ecall(input logic [31:0] ms);
    return (ms & ~32'h0000_1888) | 32'h0000_1800 | (((ms >> 3) & 32'd1) << 7);
  endfunction

  function automatic logic [31:0] ms_mret(input logic [31:0] ms);
    return (ms & ~32'h0000_1888) | 32'h0000_1880 | (((ms >> 7) & 32'd1) << 3);
  endfunction

  task automatic set_csr(input logic [11:0] a, input logic [31:0] v);
    csr_mem[a] = v;
    case (a)
      12'h300: m_mstatus = v;
      12'h305: m_mtvec   = v;
      12'h341: m_mepc    = v;
      12'h342: m_mcause  = v;
      default: ;
    endcase
  endtask

  // One clock: record any CSR write, let the CSR file commit it after the edge.
  task automatic cyc();
    logic        pend;
    logic [11:0] pa;
    logic [31:0] pd;
    #1;
    pend = o_csr_wen;
    pa   = o_csr_addr;
    pd   = o_csr_wdata;
    if (pend) obs_q.push_back({pa, pd});
    @(posedge i_clock);
    #1;
    if (pend) csr_mem[pa] = pd;
    @(negedge i_clock);
  endtask

  task automatic run_trap(input logic ec, input logic mr, input logic [31:0] pc,
                          input logic [31:0] cause, input int stall);
    logic [43:0] exp_q [$];
    logic [31:0] tgt;
    int exp_lat;
    int lat;
    exp_q = {};
    if (ec) begin
      exp_q.push_back({12'h341, pc});
      exp_q.push_back({12'h342, cause});
      exp_q.push_back({12'h300, ms_ecall(m_mstatus)});
      tgt       = m_mtvec & TB_MASK;
      exp_lat   = 5;
      m_mepc    = pc;
      m_mcause  = cause;
      m_mstatus = ms_ecall(m_mstatus);
    end else begin
      exp_q.push_back({12'h300, ms_mret(m_mstatus)});
      tgt       = m_mepc & TB_MASK;
      exp_lat   = 3;
      m_mstatus = ms_mret(m_mstatus);
    end
    obs_q.delete();
    chk("ready_idle", 64'(o_exc_ready), 64'd1);
    i_exc_valid = 1'b1;
    i_exc_ecall = ec;
    i_exc_mret  = mr;
    i_pc        = pc;
    i_mcause    = cause;
    cyc();
    // Scramble request inputs: the captured copy must be the one used.
    i_exc_valid = 1'b0;
    i_exc_ecall = 1'($urandom);
    i_exc_mret  = 1'($urandom);
    i_pc        = $urandom;
    i_mcause    = $urandom;
    lat = 1;
    while (!o_redirect_valid && lat < 20) begin
      chk("busy_seq", 64'(o_busy), 64'd1);
      cyc();
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    if (!o_redirect_valid) return;
    for (int k = 0; k < stall; k++) begin
      chk("redir_valid", 64'(o_redirect_valid), 64'd1);
      chk("redir_pc", 64'(o_redirect_pc), 64'(tgt));
      chk("redir_csr_idle", 64'({o_csr_wen, o_csr_addr, o_csr_wdata}), 64'd0);
      chk("redir_ready_lo", 64'(o_exc_ready), 64'd0);
      cyc();
    end
    i_redirect_ready = 1'b1;
    chk("hs_valid", 64'(o_redirect_valid), 64'd1);
    chk("hs_pc", 64'(o_redirect_pc), 64'(tgt));
    chk("hs_ready_lo", 64'(o_exc_ready), 64'd0);
    cyc();
    i_redirect_ready = 1'b0;
    chk("post_ready", 64'(o_exc_ready), 64'd1);
    chk("post_busy", 64'(o_busy), 64'd0);
    chk("post_valid", 64'(o_redirect_valid), 64'd0);
    chk("nwr", 64'(obs_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) chk("wr", 64'(obs_q[i]), 64'(exp_q[i]));
    end
  endtask

  initial begin
    logic [31:0] apc;
    i_reset          = 1'b1;
    i_exc_valid      = 1'b1;
    i_exc_ecall      = 1'b1;
    i_exc_mret       = 1'b0;
    i_pc             = 32'h8000_0000;
    i_mcause         = 32'd11;
    i_redirect_ready = 1'b0;
    set_csr(12'h300, 32'h0000_0008);
    set_csr(12'h305, 32'h8000_0103);
    set_csr(12'h341, 32'h0);
    set_csr(12'h342, 32'h0);
    @(negedge i_clock);
    repeat (3) cyc();
    chk("rst_busy_held", 64'(o_busy), 64'd0);
    i_exc_valid = 1'b0;
    i_reset     = 1'b0;
    chk("rst_ready", 64'(o_exc_ready), 64'd1);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_csr", 64'({o_csr_wen, o_csr_addr, o_csr_wdata}), 64'd0);
    chk("rst_redir", 64'({o_redirect_valid, o_redirect_pc}), 64'd0);
    chk("rst_nwr", 64'(obs_q.size()), 64'd0);

    // Directed reference cases.
    run_trap(1'b1, 1'b0, 32'h8000_0010, 32'd11, 0);
    chk("ecall_redir_tgt_model", 64'(m_mstatus), 64'h1880);
    set_csr(12'h341, 32'h8000_0014);
    run_trap(1'b0, 1'b1, 32'h1234_5678, 32'd0, 1);
    run_trap(1'b1, 1'b1, 32'h8000_0020, 32'd11, 0);
    run_trap(1'b0, 1'b1, 32'h0, 32'h0, 4);

    // Neither kind set: stays idle, no writes.
    obs_q.delete();
    i_exc_valid = 1'b1;
    i_exc_ecall = 1'b0;
    i_exc_mret  = 1'b0;
    repeat (3) begin
      chk("nokind_ready", 64'(o_exc_ready), 64'd1);
      chk("nokind_busy", 64'(o_busy), 64'd0);
      cyc();
    end
    i_exc_valid = 1'b0;
    chk("nokind_nwr", 64'(obs_q.size()), 64'd0);

    // Reset during W_CAUSE aborts the ECALL after the mepc write.
    obs_q.delete();
    apc = 32'h8000_0044;
    i_exc_valid = 1'b1;
    i_exc_ecall = 1'b1;
    i_pc        = apc;
    i_mcause    = 32'd8;
    cyc();
    i_exc_valid = 1'b0;
    cyc();
    i_reset = 1'b1;
    cyc();
    i_reset = 1'b0;
    m_mepc  = apc;
    chk("abort_ready", 64'(o_exc_ready), 64'd1);
    chk("abort_busy", 64'(o_busy), 64'd0);
    repeat (6) begin
      chk("abort_redir", 64'(o_redirect_valid), 64'd0);
      cyc();
    end
    chk("abort_nwr", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() > 0) chk("abort_wr", 64'(obs_q[0]), 64'({12'h341, apc}));

    // Randomized traffic.
    for (int t = 0; t < 30; t++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      set_csr(12'h300, $urandom);
      set_csr(12'h305, $urandom);
      if (kind == 1 && $urandom_range(0, 1) == 1) set_csr(12'h341, $urandom);
      run_trap(kind != 1, kind != 0, $urandom, $urandom, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) begin
        chk("gap_ready", 64'(o_exc_ready), 64'd1);
        cyc();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
